// File: rtl/regfile_trace_monitor.sv
// Register-file shadow with a timestamped write trace (FWFT valid/ready, drops counted when full) and a non-zero register dump engine.
// Optional macro REGFILE_TRACE_WATCH_EN adds a sticky address/data watchpoint (watch_addr, watch_data, watch_clr, watch_hit).

module rtm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             push_acc;
  logic             pop_acc;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_acc  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_acc = push && (!full || pop_acc);
  assign head_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr[PW-1:0]] <= push_dat;
  end
endmodule

module regfile_trace_monitor #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_REGS    = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int CYCLE_WIDTH = 16,
  parameter int STATUS_REG  = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rf_we,
  input  logic [ADDR_WIDTH-1:0]  rf_waddr,
  input  logic [DATA_WIDTH-1:0]  rf_wdata,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [ADDR_WIDTH-1:0]  trc_addr,
  output logic [DATA_WIDTH-1:0]  trc_data,
  output logic [CYCLE_WIDTH-1:0] trc_cycle,
  output logic                   trc_status,
  output logic [7:0]             overflow_cnt,
`ifdef REGFILE_TRACE_WATCH_EN
  input  logic [ADDR_WIDTH-1:0]  watch_addr,
  input  logic [DATA_WIDTH-1:0]  watch_data,
  input  logic                   watch_clr,
  output logic                   watch_hit,
`endif
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [ADDR_WIDTH-1:0]  dump_addr,
  output logic [DATA_WIDTH-1:0]  dump_data,
  output logic                   dump_done
);
  localparam logic [ADDR_WIDTH:0]   NREG     = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] STAT_IDX = ADDR_WIDTH'(STATUS_REG);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [CYCLE_WIDTH-1:0] cycle;
    logic                   status;
  } evt_t;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} dstate_t;

  logic [DATA_WIDTH-1:0]  shadow [NUM_REGS];
  logic [CYCLE_WIDTH-1:0] cyc;
  logic                   wr_ok;
  evt_t                   evt_in;
  evt_t                   evt_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   trc_pop;
  logic [7:0]             ovf;

  dstate_t                state;
  dstate_t                state_nxt;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_data;
  logic                   scan_nz;
  logic                   at_last;

  assign wr_ok = rf_we && (rf_waddr != '0) && ({1'b0, rf_waddr} < NREG);

  always_ff @(posedge clock) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + CYCLE_WIDTH'(1);
  end

  // r0 is never written, so it reads zero without a special case.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (wr_ok) begin
      shadow[rf_waddr] <= rf_wdata;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < NREG) ? shadow[rd_addr] : '0;

  always_comb begin
    evt_in        = '0;
    evt_in.addr   = rf_waddr;
    evt_in.data   = rf_wdata;
    evt_in.cycle  = cyc;
    evt_in.status = (rf_waddr == STAT_IDX);
  end

  rtm_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_ok),
    .push_dat (evt_in),
    .pop      (trc_pop),
    .head_dat (evt_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign trc_valid  = !fifo_empty;
  assign trc_pop    = trc_valid && trc_ready;
  assign trc_addr   = trc_valid ? evt_head.addr   : '0;
  assign trc_data   = trc_valid ? evt_head.data   : '0;
  assign trc_cycle  = trc_valid ? evt_head.cycle  : '0;
  assign trc_status = trc_valid ? evt_head.status : 1'b0;

  always_ff @(posedge clock) begin
    if (reset)
      ovf <= '0;
    else if (wr_ok && fifo_full && !trc_pop && (ovf != 8'hFF))
      ovf <= ovf + 8'd1;
  end
  assign overflow_cnt = ovf;

`ifdef REGFILE_TRACE_WATCH_EN
  logic watch_now;
  assign watch_now = wr_ok && (rf_waddr == watch_addr) && (rf_wdata == watch_data);

  always_ff @(posedge clock) begin
    if (reset)          watch_hit <= 1'b0;
    else if (watch_now) watch_hit <= 1'b1;
    else if (watch_clr) watch_hit <= 1'b0;
  end
`endif

  assign scan_nz = (shadow[idx] != '0);
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dump_start) state_nxt = SCAN;
      SCAN: begin
        if (scan_nz)      state_nxt = EMIT;
        else if (at_last) state_nxt = DONE;
      end
      EMIT: if (dump_ready) state_nxt = at_last ? DONE : SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The EMIT beat is latched, so later writes to that register do not disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        IDLE: if (dump_start) idx <= ADDR_WIDTH'(1);
        SCAN: begin
          if (scan_nz) begin
            lat_addr <= idx;
            lat_data <= shadow[idx];
          end else if (!at_last) begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end
        EMIT: if (dump_ready && !at_last) idx <= idx + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    dump_busy  = (state != IDLE);
    dump_valid = (state == EMIT);
    dump_done  = (state == DONE);
    dump_addr  = '0;
    dump_data  = '0;
    if (state == EMIT) begin
      dump_addr = lat_addr;
      dump_data = lat_data;
    end
  end
endmodule

// File: tb/tb_regfile_trace_monitor.sv
// Bench for regfile_trace_monitor: directed steps plus random traffic against a queue/array reference model.
`timescale 1ns/1ps
module tb_regfile_trace_monitor;
  localparam int AW = 5, DW = 32, NR = 32, FD = 8, CW = 16, SR = 30;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rf_we = 1'b0;
  logic [AW-1:0] rf_waddr = '0;
  logic [DW-1:0] rf_wdata = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          trc_valid;
  logic          trc_ready = 1'b0;
  logic [AW-1:0] trc_addr;
  logic [DW-1:0] trc_data;
  logic [CW-1:0] trc_cycle;
  logic          trc_status;
  logic [7:0]    overflow_cnt;
  logic          dump_start = 1'b0;
  logic          dump_busy;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_done;
`ifdef REGFILE_TRACE_WATCH_EN
  logic [AW-1:0] watch_addr = '0;
  logic [DW-1:0] watch_data = '0;
  logic          watch_clr = 1'b0;
  logic          watch_hit;
`endif

  regfile_trace_monitor dut (
    .clock(clock), .reset(reset),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_addr(trc_addr),
    .trc_data(trc_data), .trc_cycle(trc_cycle), .trc_status(trc_status),
    .overflow_cnt(overflow_cnt),
`ifdef REGFILE_TRACE_WATCH_EN
    .watch_addr(watch_addr), .watch_data(watch_data), .watch_clr(watch_clr), .watch_hit(watch_hit),
`endif
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference model: architectural shadow array, event queue, drop counter, free-running cycle count.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cyc;
    logic          st;
  } ev_t;

  ev_t           q[$];
  logic [DW-1:0] m_sh [NR];
  int            m_ovf = 0;
  int unsigned   m_cyc = 0;

  task automatic tick();
    ev_t e;
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_cyc = 0;
      foreach (m_sh[i]) m_sh[i] = '0;
    end else begin
      if (q.size() > 0 && trc_ready) void'(q.pop_front());
      if (rf_we && rf_waddr != 0 && int'(rf_waddr) < NR) begin
        m_sh[rf_waddr] = rf_wdata;
        if (q.size() < FD) begin
          e.addr = rf_waddr;
          e.data = rf_wdata;
          e.cyc  = CW'(m_cyc);
          e.st   = (int'(rf_waddr) == SR);
          q.push_back(e);
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
      m_cyc = (m_cyc + 1) % (1 << CW);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    rf_we = 1'b1;
    rf_waddr = AW'(a);
    rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic check_trc(input string tag);
    chk({tag, ".rd_data"}, rd_data, m_sh[rd_addr]);
    chk({tag, ".trc_valid"}, trc_valid, q.size() > 0);
    chk({tag, ".overflow"}, overflow_cnt, m_ovf);
    if (q.size() > 0) begin
      chk({tag, ".trc_addr"}, trc_addr, q[0].addr);
      chk({tag, ".trc_data"}, trc_data, q[0].data);
      chk({tag, ".trc_cycle"}, trc_cycle, q[0].cyc);
      chk({tag, ".trc_status"}, trc_status, q[0].st);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, beats, stall, dones;
    int exp_a[$];

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst.rd_data", rd_data, 0);
    chk("rst.trc_valid", trc_valid, 0);
    chk("rst.trc_addr", trc_addr, 0);
    chk("rst.trc_data", trc_data, 0);
    chk("rst.trc_cycle", trc_cycle, 0);
    chk("rst.trc_status", trc_status, 0);
    chk("rst.overflow", overflow_cnt, 0);
    chk("rst.dump_busy", dump_busy, 0);
    chk("rst.dump_valid", dump_valid, 0);
    chk("rst.dump_addr", dump_addr, 0);
    chk("rst.dump_data", dump_data, 0);
    chk("rst.dump_done", dump_done, 0);
`ifdef REGFILE_TRACE_WATCH_EN
    chk("rst.watch_hit", watch_hit, 0);
`endif
    reset = 1'b0;

    // First write at cycle 10
    repeat (10) tick();
    rd_addr = AW'(5);
    wr(5, 32'h0000_00AA);
    chk("w5.rd_data", rd_data, 32'hAA);
    chk("w5.trc_valid", trc_valid, 1);
    chk("w5.trc_addr", trc_addr, 5);
    chk("w5.trc_data", trc_data, 32'hAA);
    chk("w5.trc_cycle", trc_cycle, 10);
    chk("w5.trc_status", trc_status, 0);
    check_trc("w5");

    // r0 write is ignored; r30 flags status
    trc_ready = 1'b1;
    tick();
    rd_addr = '0;
    wr(0, 32'hFFFF_FFFF);
    chk("r0.rd_data", rd_data, 0);
    chk("r0.no_event", trc_valid, 0);
    rd_addr = AW'(30);
    wr(30, 32'h1);
    chk("r30.trc_status", trc_status, 1);
    chk("r30.trc_addr", trc_addr, 30);
    check_trc("r30");
    tick();

    // Overflow with consumer stalled
    trc_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      rd_addr = AW'(i);
      wr(i, 32'h100 + i);
      check_trc("fill");
    end
    chk("ovf.count", overflow_cnt, 2);
    chk("ovf.head", trc_data, 32'h101);
    // push and pop while full: accepted, no drop
    trc_ready = 1'b1;
    wr(11, 32'h111);
    chk("full_pp.overflow", overflow_cnt, 2);
    for (int k = 2; k <= 8; k++) begin
      chk("drain.order", trc_data, 32'h100 + k);
      check_trc("drain");
      tick();
    end
    chk("drain.last", trc_data, 32'h111);
    tick();
    chk("drain.empty", trc_valid, 0);

    // Random traffic against the model
    for (int r = 0; r < 400; r++) begin
      rf_we     = 1'($urandom_range(0, 1));
      rf_waddr  = AW'($urandom);
      rf_wdata  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      trc_ready = (r < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rd_addr   = AW'($urandom);
      tick();
      check_trc("rnd");
    end
    rf_we = 1'b0;

    // All-zero dump: no beats, done NUM_REGS cycles after start
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dump_start = 1'b1;
    n = 0;
    beats = 0;
    do begin
      tick();
      dump_start = 1'b0;
      n++;
      if (dump_valid) beats++;
    end while (!dump_done && n < 100);
    chk("zdump.latency", n, NR);
    chk("zdump.beats", beats, 0);
    tick();
    chk("zdump.idle", dump_busy, 0);

    // Dump of r3=7, r31=9 with stalled consumer
    trc_ready = 1'b1;
    wr(3, 32'd7);
    wr(31, 32'd9);
    exp_a.delete();
    for (int i = 1; i < NR; i++) if (m_sh[i] != 0) exp_a.push_back(i);
    dump_ready = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    beats = 0;
    stall = 0;
    dones = 0;
    for (int c = 0; c < 120; c++) begin
      if (dump_valid) begin
        if (beats < exp_a.size()) begin
          chk("dump.addr", dump_addr, exp_a[beats]);
          chk("dump.data", dump_data, m_sh[exp_a[beats]]);
        end else begin
          chk("dump.extra_beat", dump_valid, 0);
        end
        if (stall < 3) begin
          stall++;
          dump_ready = 1'b0;
        end else begin
          stall = 0;
          dump_ready = 1'b1;
          beats++;
        end
      end else begin
        dump_ready = 1'b0;
      end
      if (dump_done) dones++;
      if (c == 6) chk("dump.busy_mid", dump_busy, 1);
      dump_start = (c == 6);
      tick();
    end
    chk("dump.beats", beats, 2);
    chk("dump.done_pulses", dones, 1);
    chk("dump.idle_after", dump_busy, 0);

    // Reset while a beat is being emitted
    trc_ready = 1'b0;
    for (int i = 1; i <= 10; i++) wr(i, 32'h200 + i);
    chk("emit_rst.pre_ovf", overflow_cnt, 2);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n = 0;
    while (!dump_valid && n < 50) begin
      tick();
      n++;
    end
    chk("emit_rst.in_emit", dump_valid, 1);
    reset = 1'b1;
    tick();
    chk("emit_rst.busy", dump_busy, 0);
    chk("emit_rst.trc_valid", trc_valid, 0);
    chk("emit_rst.overflow", overflow_cnt, 0);
    for (int i = 0; i < NR; i++) begin
      rd_addr = AW'(i);
      #1;
      chk("emit_rst.shadow", rd_data, 0);
    end
    reset = 1'b0;
    tick();

`ifdef REGFILE_TRACE_WATCH_EN
    trc_ready = 1'b1;
    watch_addr = AW'(7);
    watch_data = 32'h1234;
    wr(7, 32'h1233);
    chk("watch.miss", watch_hit, 0);
    wr(7, 32'h1234);
    chk("watch.hit", watch_hit, 1);
    tick();
    chk("watch.sticky", watch_hit, 1);
    watch_clr = 1'b1;
    tick();
    watch_clr = 1'b0;
    chk("watch.cleared", watch_hit, 0);
    watch_clr = 1'b1;
    wr(7, 32'h1234);
    watch_clr = 1'b0;
    chk("watch.hit_beats_clr", watch_hit, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
